// File: rtl/stack_addr_unit.sv
// Stack/address generation unit: selects a memory address from register-indirect,
// stack push/pop or direct sources, with a one-cycle registered result and sticky error flags.
module stack_addr_unit #(
   parameter int unsigned        ADDR_W      = 16,
   parameter logic [ADDR_W-1:0]  STACK_TOP   = 16'hFFFF,
   parameter int unsigned        STACK_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              reg_addr,
   input  logic              push,
   input  logic              pop,
   input  logic              sp_load,
   input  logic [ADDR_W-1:0] sp_load_val,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] alu_result,
   output logic [ADDR_W-1:0] true_addr,
   output logic              addr_valid,
   output logic [ADDR_W-1:0] sp,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow,
   output logic              conflict
);

   localparam logic [ADDR_W-1:0] SP_FULL = STACK_TOP - ADDR_W'(STACK_DEPTH);
   localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      OP_NONE   = 3'd0,
      OP_REG    = 3'd1,
      OP_PUSH   = 3'd2,
      OP_POP    = 3'd3,
      OP_DIRECT = 3'd4,
      OP_OVF    = 3'd5,
      OP_UNF    = 3'd6,
      OP_CONF   = 3'd7
   } op_e;

   logic [ADDR_W-1:0] sp_q, sp_d, sp_step_s;
   logic [ADDR_W-1:0] true_addr_q, true_addr_d;
   logic              addr_valid_q, addr_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              conflict_q, conflict_d;
   logic              full_s, empty_s;
   op_e               op_s;

   // Full/empty follow the raw SP compare, even after an out-of-range load.
   always_comb begin
      full_s  = (sp_q == SP_FULL);
      empty_s = (sp_q == STACK_TOP);
   end

   // Classify the current request; reg_addr masks push/pop entirely.
   always_comb begin
      op_s = OP_NONE;
      if (req) begin
         if (reg_addr) begin
            op_s = OP_REG;
         end else if (push && pop) begin
            op_s = OP_CONF;
         end else if (push) begin
            op_s = full_s ? OP_OVF : OP_PUSH;
         end else if (pop) begin
            op_s = empty_s ? OP_UNF : OP_POP;
         end else begin
            op_s = OP_DIRECT;
         end
      end else begin
         op_s = OP_NONE;
      end
   end

   // Next-state for address, valid, SP step and sticky flags.
   always_comb begin
      true_addr_d  = true_addr_q;
      addr_valid_d = 1'b0;
      sp_step_s    = sp_q;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      conflict_d   = conflict_q;
      case (op_s)
         OP_REG: begin
            true_addr_d  = alu_result;
            addr_valid_d = 1'b1;
         end
         OP_PUSH: begin
            true_addr_d  = sp_q - SP_ONE;
            addr_valid_d = 1'b1;
            sp_step_s    = sp_q - SP_ONE;
         end
         OP_POP: begin
            true_addr_d  = sp_q;
            addr_valid_d = 1'b1;
            sp_step_s    = sp_q + SP_ONE;
         end
         OP_DIRECT: begin
            true_addr_d  = addr;
            addr_valid_d = 1'b1;
         end
         OP_OVF:  overflow_d  = 1'b1;
         OP_UNF:  underflow_d = 1'b1;
         OP_CONF: conflict_d  = 1'b1;
         default: begin
            true_addr_d  = true_addr_q;
            addr_valid_d = 1'b0;
         end
      endcase
   end

   // An SP load wins over the stack step; the address above already used the old SP.
   always_comb begin
      if (sp_load) begin
         sp_d = sp_load_val;
      end else begin
         sp_d = sp_step_s;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q         <= STACK_TOP;
         true_addr_q  <= '0;
         addr_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         conflict_q   <= 1'b0;
      end else begin
         sp_q         <= sp_d;
         true_addr_q  <= true_addr_d;
         addr_valid_q <= addr_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         conflict_q   <= conflict_d;
      end
   end

   assign true_addr  = true_addr_q;
   assign addr_valid = addr_valid_q;
   assign sp         = sp_q;
   assign full       = full_s;
   assign empty      = empty_s;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;
   assign conflict   = conflict_q;

endmodule

// File: tb/tb_stack_addr_unit.sv
// Directed self-checking bench for stack_addr_unit with hand-computed expectations.
module tb_stack_addr_unit;

   logic        clk;
   logic        rst;
   logic        req, reg_addr, push, pop, sp_load;
   logic [15:0] sp_load_val, addr, alu_result;
   logic [15:0] true_addr, sp;
   logic        addr_valid, full, empty, overflow, underflow, conflict;

   int tests_run    = 0;
   int tests_failed = 0;

   stack_addr_unit dut (
      .clk(clk), .rst(rst), .req(req), .reg_addr(reg_addr), .push(push), .pop(pop),
      .sp_load(sp_load), .sp_load_val(sp_load_val), .addr(addr), .alu_result(alu_result),
      .true_addr(true_addr), .addr_valid(addr_valid), .sp(sp), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow), .conflict(conflict)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 1'b0; reg_addr = 1'b0; push = 1'b0; pop = 1'b0; sp_load = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_sp"},    32'(sp), 32'hFFFF);
      check({tag, "_valid"}, 32'(addr_valid), 32'd0);
      check({tag, "_taddr"}, 32'(true_addr), 32'h0000);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_full"},  32'(full), 32'd0);
      check({tag, "_flags"}, {29'd0, overflow, underflow, conflict}, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      idle();
      sp_load_val = 16'h0000; addr = 16'h0000; alu_result = 16'h0000;
      #2 rst = 1'b1;
      #2;
      check_reset_state("rst0");
      step();
      step();
      rst = 1'b0;

      // Direct address
      req = 1'b1; addr = 16'h1234;
      step();
      check("dir_taddr", 32'(true_addr), 32'h1234);
      check("dir_valid", 32'(addr_valid), 32'd1);
      check("dir_sp", 32'(sp), 32'hFFFF);
      idle();
      step();
      check("idle_valid", 32'(addr_valid), 32'd0);
      check("idle_hold", 32'(true_addr), 32'h1234);

      // Three pushes then three pops
      req = 1'b1; push = 1'b1;
      step(); check("push1", 32'(true_addr), 32'hFFFE);
      step(); check("push2", 32'(true_addr), 32'hFFFD);
      step(); check("push3", 32'(true_addr), 32'hFFFC);
      check("push_sp", 32'(sp), 32'hFFFC);
      check("push_valid", 32'(addr_valid), 32'd1);
      push = 1'b0; pop = 1'b1;
      step(); check("pop1", 32'(true_addr), 32'hFFFC);
      step(); check("pop2", 32'(true_addr), 32'hFFFD);
      step(); check("pop3", 32'(true_addr), 32'hFFFE);
      check("pop_sp", 32'(sp), 32'hFFFF);
      check("pop_empty", 32'(empty), 32'd1);

      // Pop while empty
      step();
      check("unf_valid", 32'(addr_valid), 32'd0);
      check("unf_flag", 32'(underflow), 32'd1);
      check("unf_sp", 32'(sp), 32'hFFFF);
      idle();
      step();
      check("unf_sticky", 32'(underflow), 32'd1);

      // Fill to 256 entries, then overflow
      req = 1'b1; push = 1'b1;
      for (int i = 0; i < 256; i++) step();
      check("fill_sp", 32'(sp), 32'hFEFF);
      check("fill_taddr", 32'(true_addr), 32'hFEFF);
      check("fill_full", 32'(full), 32'd1);
      check("fill_novf", 32'(overflow), 32'd0);
      step();
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_valid", 32'(addr_valid), 32'd0);
      check("ovf_sp", 32'(sp), 32'hFEFF);
      idle();
      pulse_reset();
      check_reset_state("rst1");

      // Push/pop conflict
      req = 1'b1; push = 1'b1; pop = 1'b1;
      step();
      check("conf_flag", 32'(conflict), 32'd1);
      check("conf_valid", 32'(addr_valid), 32'd0);
      check("conf_sp", 32'(sp), 32'hFFFF);
      idle();
      pulse_reset();

      // reg_addr masks push/pop
      req = 1'b1; push = 1'b1; pop = 1'b1; reg_addr = 1'b1; alu_result = 16'h00A0;
      step();
      check("reg_taddr", 32'(true_addr), 32'h00A0);
      check("reg_valid", 32'(addr_valid), 32'd1);
      check("reg_noconf", 32'(conflict), 32'd0);
      check("reg_sp", 32'(sp), 32'hFFFF);
      idle();

      // SP load concurrent with push
      req = 1'b1; push = 1'b1;
      step();
      check("ld_pre_sp", 32'(sp), 32'hFFFE);
      sp_load = 1'b1; sp_load_val = 16'hFF80;
      step();
      check("ld_taddr", 32'(true_addr), 32'hFFFD);
      check("ld_sp", 32'(sp), 32'hFF80);
      check("ld_flags", {30'd0, full, empty}, 32'd0);
      idle();

      // Out-of-range load, then pop and a full-boundary load
      sp_load = 1'b1; sp_load_val = 16'h0005;
      step();
      sp_load = 1'b0; req = 1'b1; pop = 1'b1;
      step();
      check("oor_taddr", 32'(true_addr), 32'h0005);
      check("oor_sp", 32'(sp), 32'h0006);
      check("oor_unf", 32'(underflow), 32'd0);
      idle();
      sp_load = 1'b1; sp_load_val = 16'hFEFF;
      step();
      check("ldfull_full", 32'(full), 32'd1);
      idle();

      // Reset mid-stream after five pushes with a pending request
      pulse_reset();
      req = 1'b1; push = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("mid_sp", 32'(sp), 32'hFFFA);
      push = 1'b0; pop = 1'b1;
      sp_load = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("rst2");
      step();
      rst = 1'b0; idle();
      step();
      check("post_rst_valid", 32'(addr_valid), 32'd0);
      req = 1'b1; addr = 16'h5555;
      step();
      check("post_rst_taddr", 32'(true_addr), 32'h5555);
      check("post_rst_valid2", 32'(addr_valid), 32'd1);
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/stack_addr_unit.md
STACK_ADDR_UNIT -- requirements
Module: stack_addr_unit

Interface
REQ-001 Parameter ADDR_W, default 16: width of every address bus and of the stack pointer.
REQ-002 Parameter STACK_TOP, default 16'hFFFF: empty-stack SP value; stack grows downward from here.
REQ-003 Parameter STACK_DEPTH, default 256: maximum entries; legal SP range [STACK_TOP-STACK_DEPTH, STACK_TOP].
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  address request strobe; inputs sampled only when req=1.
REQ-007 reg_addr  input  1  register-indirect select; true_addr comes from alu_result.
REQ-008 push  input  1  stack push request.
REQ-009 pop  input  1  stack pop request.
REQ-010 sp_load  input  1  synchronous SP load strobe.
REQ-011 sp_load_val  input  ADDR_W  value loaded into SP when sp_load=1.
REQ-012 addr  input  ADDR_W  direct address.
REQ-013 alu_result  input  ADDR_W  computed indirect address.
REQ-014 true_addr  output  ADDR_W  registered memory address.
REQ-015 addr_valid  output  1  true_addr valid this cycle.
REQ-016 sp  output  ADDR_W  current stack pointer.
REQ-017 full, empty  output  1 each  combinational from SP: full when SP=STACK_TOP-STACK_DEPTH, empty when SP=STACK_TOP.
REQ-018 overflow, underflow, conflict  output  1 each  sticky error flags.

Function
REQ-019 Source priority on a req cycle: reg_addr, then push/pop, then addr.
REQ-020 Latency exactly 1 cycle: inputs sampled on edge N drive true_addr and addr_valid=1 during cycle N+1.
REQ-021 addr_valid=0 on every cycle after a cycle with req=0 or a rejected request; true_addr holds its last value.
REQ-022 Push (reg_addr=0, push=1, pop=0, full=0): true_addr=SP-1, SP<=SP-1 (pre-decrement).
REQ-023 Pop (reg_addr=0, pop=1, push=0, empty=0): true_addr=SP, SP<=SP+1 (post-increment).
REQ-024 Push while full: rejected, SP unchanged, addr_valid=0 next cycle, overflow set.
REQ-025 Pop while empty: rejected, SP unchanged, addr_valid=0 next cycle, underflow set.
REQ-026 push=1 and pop=1 with reg_addr=0: rejected, SP unchanged, addr_valid=0, conflict set.
REQ-027 reg_addr=1 ignores push/pop entirely: SP unchanged, no flag changes.
REQ-028 sp_load=1 overrides any push/pop SP update in the same cycle; addresses for that cycle's request still use pre-load SP.
REQ-029 sp_load_val outside legal range is loaded unchanged; full/empty then follow REQ-017 comparisons only.
REQ-030 SP arithmetic is modulo 2^ADDR_W; no saturation beyond the full/empty checks.
REQ-031 Sticky flags clear only on reset.

Reset
REQ-032 rst=1 asynchronously forces SP=STACK_TOP, true_addr=0, addr_valid=0, overflow=underflow=conflict=0; empty=1, full=0.
REQ-033 A request in flight when rst asserts is discarded; first valid output is 1 cycle after the first req following rst deassertion.

Verification
REQ-034 Reset then req with addr=16'h1234, reg_addr=push=pop=0 -> next cycle true_addr=16'h1234, addr_valid=1, SP=16'hFFFF.
REQ-035 Three pushes from reset -> true_addr 16'hFFFE, 16'hFFFD, 16'hFFFC; SP=16'hFFFC; then three pops -> 16'hFFFC, 16'hFFFD, 16'hFFFE; empty=1.
REQ-036 Pop from reset -> addr_valid=0, underflow=1, SP=16'hFFFF; 256 pushes then a 257th -> full=1, overflow=1, SP=16'hFEFF.
REQ-037 push=pop=1 -> conflict=1, SP unchanged; same cycle with reg_addr=1 and alu_result=16'h00A0 -> true_addr=16'h00A0, conflict stays 0.
REQ-038 sp_load=1, sp_load_val=16'hFF80 with concurrent push -> true_addr=old SP-1, SP=16'hFF80 next cycle.
REQ-039 rst pulsed mid-stream after 5 pushes -> SP=16'hFFFF, addr_valid=0, all flags 0 immediately, independent of clk.
